// File: rtl/pipeline_if_stage.sv
// rtl/pipeline_if_stage.sv - instruction fetch stage with IF/ID register, stall buffer and deferred redirect
// Optional build macro: IF_BRANCH_DELAY_SLOT_EN (keep the word after a taken branch instead of squashing it).
module pipeline_if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] id_instruction,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc_plus4,
  output logic        id_valid
);

  typedef enum logic [1:0] {RUN, BUFFERED, REDIRECT_PENDING} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pending_target_q, pending_target_d;
  logic [31:0] buf_instr_q, buf_instr_d;
  logic [31:0] buf_pc_q, buf_pc_d;
  logic [31:0] id_instruction_q, id_instruction_d;
  logic [31:0] id_pc_q, id_pc_d;
  logic [31:0] id_pc_plus4_q, id_pc_plus4_d;
  logic        id_valid_q, id_valid_d;

  // A stall only holds IF/ID when no redirect is moving the branch out of ID.
  logic hold;
  assign hold = stall && !redirect;

  always_comb begin
    state_d          = state_q;
    pc_d             = pc_q;
    pending_target_d = pending_target_q;
    buf_instr_d      = buf_instr_q;
    buf_pc_d         = buf_pc_q;
    id_instruction_d = id_instruction_q;
    id_pc_d          = id_pc_q;
    id_pc_plus4_d    = id_pc_plus4_q;
    id_valid_d       = id_valid_q;

    case (state_q)
      RUN: begin
        if (redirect) begin
          if (imem_ready) begin
            pc_d = redirect_target;
`ifdef IF_BRANCH_DELAY_SLOT_EN
            id_instruction_d = imem_rdata;
            id_pc_d          = pc_q;
            id_pc_plus4_d    = pc_q + 32'd4;
            id_valid_d       = 1'b1;
`else
            id_instruction_d = 32'h0;
            id_valid_d       = 1'b0;
`endif
          end else begin
            pending_target_d = redirect_target;
            id_instruction_d = 32'h0;
            id_valid_d       = 1'b0;
            state_d          = REDIRECT_PENDING;
          end
        end else if (imem_ready) begin
          pc_d = pc_q + 32'd4;
          if (stall) begin
            buf_instr_d = imem_rdata;
            buf_pc_d    = pc_q;
            state_d     = BUFFERED;
          end else begin
            id_instruction_d = imem_rdata;
            id_pc_d          = pc_q;
            id_pc_plus4_d    = pc_q + 32'd4;
            id_valid_d       = 1'b1;
          end
        end else if (!stall) begin
          id_instruction_d = 32'h0;
          id_valid_d       = 1'b0;
        end
      end

      BUFFERED: begin
        if (redirect) begin
          pc_d    = redirect_target;
          state_d = RUN;
`ifdef IF_BRANCH_DELAY_SLOT_EN
          id_instruction_d = buf_instr_q;
          id_pc_d          = buf_pc_q;
          id_pc_plus4_d    = buf_pc_q + 32'd4;
          id_valid_d       = 1'b1;
`else
          id_instruction_d = 32'h0;
          id_valid_d       = 1'b0;
`endif
        end else if (!stall) begin
          id_instruction_d = buf_instr_q;
          id_pc_d          = buf_pc_q;
          id_pc_plus4_d    = buf_pc_q + 32'd4;
          id_valid_d       = 1'b1;
          state_d          = RUN;
        end
      end

      REDIRECT_PENDING: begin
        if (imem_ready) begin
          pc_d    = redirect ? redirect_target : pending_target_q;
          state_d = RUN;
`ifdef IF_BRANCH_DELAY_SLOT_EN
          if (hold) begin
            buf_instr_d = imem_rdata;
            buf_pc_d    = pc_q;
            state_d     = BUFFERED;
          end else begin
            id_instruction_d = imem_rdata;
            id_pc_d          = pc_q;
            id_pc_plus4_d    = pc_q + 32'd4;
            id_valid_d       = 1'b1;
          end
`else
          if (!hold) begin
            id_instruction_d = 32'h0;
            id_valid_d       = 1'b0;
          end
`endif
        end else begin
          if (redirect) pending_target_d = redirect_target;
          if (!hold) begin
            id_instruction_d = 32'h0;
            id_valid_d       = 1'b0;
          end
        end
      end

      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q          <= RUN;
      pc_q             <= RESET_PC;
      pending_target_q <= 32'h0;
      buf_instr_q      <= 32'h0;
      buf_pc_q         <= 32'h0;
      id_instruction_q <= 32'h0;
      id_pc_q          <= 32'h0;
      id_pc_plus4_q    <= 32'h0;
      id_valid_q       <= 1'b0;
    end else begin
      state_q          <= state_d;
      pc_q             <= pc_d;
      pending_target_q <= pending_target_d;
      buf_instr_q      <= buf_instr_d;
      buf_pc_q         <= buf_pc_d;
      id_instruction_q <= id_instruction_d;
      id_pc_q          <= id_pc_d;
      id_pc_plus4_q    <= id_pc_plus4_d;
      id_valid_q       <= id_valid_d;
    end
  end

  assign imem_req       = (state_q != BUFFERED);
  assign imem_addr      = pc_q;
  assign id_instruction = id_instruction_q;
  assign id_pc          = id_pc_q;
  assign id_pc_plus4    = id_pc_plus4_q;
  assign id_valid       = id_valid_q;

endmodule

// File: tb/tb_pipeline_if_stage.sv
// tb/tb_pipeline_if_stage.sv - vector table + scoreboard bench for pipeline_if_stage
module tb_pipeline_if_stage;

  logic        clk = 1'b0;
  logic        rst_n, stall, redirect, imem_ready;
  logic [31:0] redirect_target;
  logic        imem_req;
  logic [31:0] imem_addr, imem_rdata;
  logic [31:0] id_instruction, id_pc, id_pc_plus4;
  logic        id_valid;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  // Memory image: every word is a distinct function of its address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction
  assign imem_rdata = mem_word(imem_addr);

  pipeline_if_stage #(.RESET_PC(32'h0)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .redirect(redirect),
    .redirect_target(redirect_target), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata), .id_instruction(id_instruction),
    .id_pc(id_pc), .id_pc_plus4(id_pc_plus4), .id_valid(id_valid)
  );

  typedef struct {
    logic        rst_n, stall, redirect, ready;
    logic [31:0] target;
    logic        req;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] id_pc, id_pc4, instr;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];

  function automatic vec_t mk(input logic r, input logic s, input logic rd, input logic [31:0] t,
                              input logic rdy, input logic req, input logic [31:0] addr,
                              input logic v, input logic [31:0] ipc, input logic [31:0] ipc4);
    vec_t x;
    x.rst_n = r; x.stall = s; x.redirect = rd; x.target = t; x.ready = rdy;
    x.req = req; x.addr = addr; x.valid = v; x.id_pc = ipc; x.id_pc4 = ipc4;
    x.instr = v ? mem_word(ipc) : 32'h0;
    return x;
  endfunction

  task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic apply(input vec_t v, input int idx);
    vec_t e;
    rst_n = v.rst_n; stall = v.stall; redirect = v.redirect;
    redirect_target = v.target; imem_ready = v.ready;
    sb.push_back(v);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check("imem_req", idx, {31'h0, imem_req}, {31'h0, e.req});
    check("imem_addr", idx, imem_addr, e.addr);
    check("id_valid", idx, {31'h0, id_valid}, {31'h0, e.valid});
    check("id_pc", idx, id_pc, e.id_pc);
    check("id_pc_plus4", idx, id_pc_plus4, e.id_pc4);
    check("id_instruction", idx, id_instruction, e.instr);
  endtask

  initial begin
    //                 rst s rd target        rdy req addr           v  id_pc          id_pc4
    vecs.push_back(mk(0, 1, 1, 32'h44,        1, 1, 32'h0,          0, 32'h0,        32'h0));
    vecs.push_back(mk(1, 0, 0, 32'h0,         1, 1, 32'h4,          1, 32'h0,        32'h4));
    vecs.push_back(mk(1, 0, 0, 32'h0,         1, 1, 32'h8,          1, 32'h4,        32'h8));
    vecs.push_back(mk(1, 0, 0, 32'h0,         0, 1, 32'h8,          0, 32'h4,        32'h8));
    vecs.push_back(mk(1, 0, 0, 32'h0,         0, 1, 32'h8,          0, 32'h4,        32'h8));
    vecs.push_back(mk(1, 0, 0, 32'h0,         0, 1, 32'h8,          0, 32'h4,        32'h8));
    vecs.push_back(mk(1, 0, 0, 32'h0,         1, 1, 32'hC,          1, 32'h8,        32'hC));
    vecs.push_back(mk(1, 0, 0, 32'h0,         1, 1, 32'h10,         1, 32'hC,        32'h10));
    vecs.push_back(mk(1, 1, 0, 32'h0,         1, 0, 32'h14,         1, 32'hC,        32'h10));
    vecs.push_back(mk(1, 1, 0, 32'h0,         1, 0, 32'h14,         1, 32'hC,        32'h10));
    vecs.push_back(mk(1, 0, 0, 32'h0,         0, 1, 32'h14,         1, 32'h10,       32'h14));
    vecs.push_back(mk(1, 0, 0, 32'h0,         1, 1, 32'h18,         1, 32'h14,       32'h18));
    vecs.push_back(mk(1, 0, 0, 32'h0,         1, 1, 32'h1C,         1, 32'h18,       32'h1C));
    vecs.push_back(mk(1, 0, 0, 32'h0,         1, 1, 32'h20,         1, 32'h1C,       32'h20));
`ifdef IF_BRANCH_DELAY_SLOT_EN
    vecs.push_back(mk(1, 1, 1, 32'h40,        1, 1, 32'h40,         1, 32'h20,       32'h24));
`else
    vecs.push_back(mk(1, 1, 1, 32'h40,        1, 1, 32'h40,         0, 32'h1C,       32'h20));
`endif
    vecs.push_back(mk(1, 0, 0, 32'h0,         1, 1, 32'h44,         1, 32'h40,       32'h44));
    vecs.push_back(mk(1, 0, 1, 32'h80,        0, 1, 32'h44,         0, 32'h40,       32'h44));
    vecs.push_back(mk(1, 0, 0, 32'h0,         0, 1, 32'h44,         0, 32'h40,       32'h44));
`ifdef IF_BRANCH_DELAY_SLOT_EN
    vecs.push_back(mk(1, 0, 0, 32'h0,         1, 1, 32'h80,         1, 32'h44,       32'h48));
`else
    vecs.push_back(mk(1, 0, 0, 32'h0,         1, 1, 32'h80,         0, 32'h40,       32'h44));
`endif
    vecs.push_back(mk(1, 0, 0, 32'h0,         1, 1, 32'h84,         1, 32'h80,       32'h84));
`ifdef IF_BRANCH_DELAY_SLOT_EN
    vecs.push_back(mk(1, 0, 1, 32'hFFFF_FFFC, 1, 1, 32'hFFFF_FFFC,  1, 32'h84,       32'h88));
`else
    vecs.push_back(mk(1, 0, 1, 32'hFFFF_FFFC, 1, 1, 32'hFFFF_FFFC,  0, 32'h80,       32'h84));
`endif
    vecs.push_back(mk(1, 0, 0, 32'h0,         1, 1, 32'h0,          1, 32'hFFFF_FFFC, 32'h0));
    vecs.push_back(mk(1, 1, 0, 32'h0,         0, 1, 32'h0,          1, 32'hFFFF_FFFC, 32'h0));
    vecs.push_back(mk(1, 0, 0, 32'h0,         0, 1, 32'h0,          0, 32'hFFFF_FFFC, 32'h0));
    vecs.push_back(mk(0, 0, 0, 32'h0,         0, 1, 32'h0,          0, 32'h0,        32'h0));
    vecs.push_back(mk(1, 1, 0, 32'h0,         1, 0, 32'h4,          0, 32'h0,        32'h0));
`ifdef IF_BRANCH_DELAY_SLOT_EN
    vecs.push_back(mk(1, 1, 1, 32'h100,       0, 1, 32'h100,        1, 32'h0,        32'h4));
`else
    vecs.push_back(mk(1, 1, 1, 32'h100,       0, 1, 32'h100,        0, 32'h0,        32'h0));
`endif
    vecs.push_back(mk(1, 0, 0, 32'h0,         1, 1, 32'h104,        1, 32'h100,      32'h104));

    foreach (vecs[i]) apply(vecs[i], i);

    // Reset while a redirect is pending: pending target must not survive reset.
    apply(mk(1, 0, 1, 32'h200, 0, 1, 32'h104, 0, 32'h100, 32'h104), 100);
    apply(mk(0, 0, 1, 32'h300, 0, 1, 32'h0,   0, 32'h0,   32'h0),   101);
    apply(mk(1, 0, 0, 32'h0,   1, 1, 32'h4,   1, 32'h0,   32'h4),   102);
    apply(mk(1, 0, 0, 32'h0,   1, 1, 32'h8,   1, 32'h4,   32'h8),   103);

    check("scoreboard_empty", 200, sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
